fifo_rd_stream: RTL

// - Read-side adapter placed directly after the async FIFO, in the rdclk domain.
// - Turns the FIFO's rd/empty/dataout interface into a valid/ready stream (m_valid/m_ready/m_data).
// - Prefetches FIFO words into a 2-entry skid buffer so the stream can deliver one beat per clock.
// - Keeps a delivered-beat counter for debug.

---
 rtl/fifo_rd_stream.sv | 74 +++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: prefetches words into a 2-entry skid
// buffer and presents them as a valid/ready stream with a delivered-beat counter.
module fifo_rd_stream #(
  parameter int WIDTH    = 8,
  parameter int CNTWIDTH = 16
) (
  input  logic                rdclk,
  input  logic                reset,
  input  logic                fifo_empty,
  input  logic [WIDTH-1:0]    fifo_data,
  output logic                fifo_rd,
  output logic                m_valid,
  output logic [WIDTH-1:0]    m_data,
  input  logic                m_ready,
  output logic [CNTWIDTH-1:0] beat_count
);

  logic [1:0]          occ_q, occ_d;
  logic                infl_q;
  logic [WIDTH-1:0]    buf0_q, buf0_d;
  logic [WIDTH-1:0]    buf1_q, buf1_d;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;
  logic                pop;
  logic                push;
  logic [2:0]          level;
  logic [1:0]          wr_idx;

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf0_q;
  assign beat_count = cnt_q;
  assign pop        = m_valid & m_ready;
  assign push       = infl_q;

  // Occupancy the buffer will have after this edge if nothing new is issued;
  // pop implies occ >= 1, so this never underflows.
  assign level   = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign fifo_rd = reset & ~fifo_empty & (level < 3'd2);

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    cnt_d  = cnt_q + {{(CNTWIDTH-1){1'b0}}, pop};
    wr_idx = occ_q - {1'b0, pop};
    if (pop) begin
      buf0_d = buf1_q;
    end
    // The incoming word lands behind whatever survives the pop, keeping FIFO order.
    if (push) begin
      if (wr_idx == 2'd0) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
    end
  end

  always_ff @(posedge rdclk or negedge reset) begin
    if (!reset) begin
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= fifo_rd;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
